pop_streamer: RTL and testbench

POP_STREAMER -- requirements
Module: pop_streamer

---
 rtl/pop_streamer.sv | 95 +++++++++
 tb/tb_pop_streamer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_streamer.sv
// Streams a snapshotted population one individual per accepted beat.
// A start rising edge latches the population and begins one pass.
module pop_streamer #(
  parameter int NUM_IND   = 100,
  parameter int IND_WIDTH = 75,
  parameter int IDX_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_IND*IND_WIDTH-1:0]  population,
  output logic [IND_WIDTH-1:0]          ind_data,
  output logic [IDX_WIDTH-1:0]          ind_idx,
  output logic                          ind_valid,
  input  logic                          ind_ready,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(NUM_IND - 1);

  state_t state, state_d;

  logic [NUM_IND-1:0][IND_WIDTH-1:0] snap;
  logic                 start_q;
  logic                 start_acc;
  logic                 load;
  logic                 adv;
  logic [IDX_WIDTH-1:0] nxt_idx;

  assign start_acc = start & ~start_q;
  assign nxt_idx   = ind_idx + 1'b1;

  assign ind_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign done      = (state == DONE);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = STREAM;
          load    = 1'b1;
        end
      end
      STREAM: begin
        if (ind_ready) begin
          if (ind_idx == LAST_IDX) begin
            state_d = DONE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      start_q  <= start;
      ind_idx  <= '0;
      ind_data <= '0;
    end else begin
      state   <= state_d;
      start_q <= start;
      if (load) begin
        ind_idx  <= '0;
        ind_data <= population[IND_WIDTH-1:0];
      end else if (adv) begin
        ind_idx  <= nxt_idx;
        ind_data <= snap[nxt_idx];
      end
    end
  end

  // Snapshot is only meaningful once loaded, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset && load) begin
      snap <= population;
    end
  end

endmodule

// File: tb/tb_pop_streamer.sv
// Randomized bench for pop_streamer against a queue-based pass model.
// Each task drives one scenario and compares outputs every cycle.
module tb_pop_streamer;

  localparam int NUM_IND   = 100;
  localparam int IND_WIDTH = 75;
  localparam int IDX_WIDTH = 7;
  localparam int VW = 3 + IDX_WIDTH + IND_WIDTH;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         start = 1'b0;
  logic [NUM_IND*IND_WIDTH-1:0] population = '0;
  logic [IND_WIDTH-1:0]         ind_data;
  logic [IDX_WIDTH-1:0]         ind_idx;
  logic                         ind_valid;
  logic                         ind_ready = 1'b0;
  logic                         busy;
  logic                         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [IND_WIDTH-1:0] pend[$];
  int                   tx[$];
  logic                 m_done = 1'b0;
  logic                 m_sq = 1'b0;
  logic [IND_WIDTH-1:0] exp_data = '0;
  logic [IDX_WIDTH-1:0] exp_idx = '0;

  pop_streamer #(
    .NUM_IND  (NUM_IND),
    .IND_WIDTH(IND_WIDTH),
    .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .population(population),
    .ind_data  (ind_data),
    .ind_idx   (ind_idx),
    .ind_valid (ind_valid),
    .ind_ready (ind_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs_vec();
    return {ind_valid, busy, done, ind_idx, ind_data};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic v;
    v = (pend.size() != 0);
    return {v, v, m_done, exp_idx, exp_data};
  endfunction

  function automatic logic [IND_WIDTH-1:0] rnd_ind();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[IND_WIDTH-1:0];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NUM_IND; i++)
      population[i*IND_WIDTH +: IND_WIDTH] = rnd_ind();
  endtask

  task automatic fill_pattern();
    logic [79:0] p;
    for (int i = 0; i < NUM_IND; i++) begin
      p = {10{8'(i)}};
      population[i*IND_WIDTH +: IND_WIDTH] = p[IND_WIDTH-1:0];
    end
  endtask

  // Model step from the inputs in force before the edge, then clock.
  task automatic tick();
    logic se;
    if (reset) begin
      pend.delete();
      m_done   = 1'b0;
      exp_data = '0;
      exp_idx  = '0;
      m_sq     = start;
    end else begin
      se   = start && !m_sq;
      m_sq = start;
      if (pend.size() != 0) begin
        if (ind_ready) begin
          tx.push_back(NUM_IND - pend.size());
          void'(pend.pop_front());
          if (pend.size() == 0) m_done = 1'b1;
        end
      end else if (se) begin
        tx.delete();
        for (int i = 0; i < NUM_IND; i++)
          pend.push_back(population[i*IND_WIDTH +: IND_WIDTH]);
        m_done = 1'b0;
      end
      if (pend.size() != 0) begin
        exp_data = pend[0];
        exp_idx  = IDX_WIDTH'(NUM_IND - pend.size());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ind_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    fill_pattern();
    ind_ready = 1'b1;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checks++;
    if (ind_valid !== 1'b1 || ind_idx !== '0) begin
      errors++;
      $display("FAIL first_beat: got v=%b idx=%0d want v=1 idx=0",
               ind_valid, ind_idx);
    end
    n = 0;
    while (pend.size() != 0 && n < 300) begin
      tick();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n != NUM_IND || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_len: got %0d cycles done=%b want %0d 1",
               n, done, NUM_IND);
    end
    ok = (tx.size() == NUM_IND);
    foreach (tx[i]) if (tx[i] != i) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_order: got %0d transfers want %0d in order",
               tx.size(), NUM_IND);
    end
    start = 1'b0;
  endtask

  task automatic test_random_ready(input bit churn);
    bit ok;
    int n;
    fill_random();
    start = 1'b0;
    ind_ready = 1'($urandom);
    tick();
    start = 1'b1;
    tick();
    n = 0;
    while (pend.size() != 0 && n < 2000) begin
      ind_ready = 1'($urandom);
      if (churn) fill_random();
      if ($urandom_range(0, 9) == 0) start = ~start;
      tick();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rand%0d c%0d: got %h want %h",
                 churn, cyc, obs_vec(), exp_vec());
      end
    end
    ok = (tx.size() == NUM_IND) && (pend.size() == 0);
    foreach (tx[i]) if (tx[i] != i) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand%0d_order: got %0d transfers want %0d",
               churn, tx.size(), NUM_IND);
    end
    ind_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_restart_ignored();
    int n;
    fill_random();
    ind_ready = 1'b1;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n = 0;
    while (pend.size() != 0 && n < 300) begin
      if (exp_idx == 7'd40) start = 1'b0;
      if (exp_idx == 7'd41) start = 1'b1;
      tick();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || ind_idx !== 7'd99) begin
        errors++;
        $display("FAIL done_hold: got done=%b idx=%0d want 1 99",
                 done, ind_idx);
      end
    end
    fill_random();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checks++;
    if (done !== 1'b0 || ind_valid !== 1'b1 || ind_idx !== '0
        || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL fresh_pass: got %h want %h",
               obs_vec(), exp_vec());
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (pend.size() != 0 && exp_idx != 7'd57 && n < 300) begin
      tick();
      n++;
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    checks++;
    if ({ind_valid, busy, done, ind_idx} !== '0
        || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid: got %h want %h",
               obs_vec(), exp_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rerun c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end while (pend.size() != 0 && n < 300);
    start = 1'b0;
  endtask

  task automatic test_start_held();
    int n;
    fill_random();
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_start c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    n = 0;
    do begin
      ind_ready = 1'($urandom);
      tick();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_pass c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end while (pend.size() != 0 && n < 2000);
    for (int i = 0; i < 40; i++) begin
      ind_ready = 1'($urandom);
      tick();
      checks++;
      if (done !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_done c%0d: got %h want %h",
                 cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready(1'b0);
    test_random_ready(1'b1);
    test_restart_ignored();
    test_reset_mid();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
